// File: rtl/edge_pulse_pkg.sv
// Shared mode encodings and sizing helper for the edge pulse generator.
package edge_pulse_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/edge_pulse_gen_if.sv
// Control and status bundle of the edge pulse generator.
interface edge_pulse_gen_if #(
    parameter int CHANNELS = 4
) ();

    logic [CHANNELS-1:0]   check;
    logic [2*CHANNELS-1:0] mode;
    logic                  enable;
    logic [CHANNELS-1:0]   clear_missed;
    logic [CHANNELS-1:0]   out;
    logic                  any_out;
    logic [CHANNELS-1:0]   missed;

    modport master (
        output check, mode, enable, clear_missed,
        input  out, any_out, missed
    );

    modport slave (
        input  check, mode, enable, clear_missed,
        output out, any_out, missed
    );

endinterface

// File: rtl/edge_pulse_chan.sv
// One channel: edge detect, pulse counter and sticky missed-edge flag.
module edge_pulse_chan
    import edge_pulse_pkg::*;
#(
    parameter int PULSE_LEN = 1,
    parameter int RETRIG    = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       chk,
    input  logic [1:0] mode,
    input  logic       enable,
    input  logic       clear_missed,
    output logic       out,
    output logic       out_nxt,
    output logic       missed
);

    localparam int CW = cnt_width(PULSE_LEN);
    localparam logic [CW-1:0] LEN = CW'(PULSE_LEN);

    logic          prev;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_dec;
    logic [CW-1:0] cnt_nxt;
    logic          rise;
    logic          fall;
    logic          hit;
    logic          miss_set;

    assign rise = chk & ~prev;
    assign fall = ~chk & prev;

    always_comb begin
        hit = 1'b0;
        unique case (mode)
            MODE_OFF:  hit = 1'b0;
            MODE_RISE: hit = rise;
            MODE_FALL: hit = fall;
            MODE_BOTH: hit = rise | fall;
        endcase
        hit = hit & enable;
    end

    assign cnt_dec = (cnt == '0) ? '0 : cnt - CW'(1);

    // A pulse in its final cycle counts as idle, so an edge then starts a fresh pulse.
    always_comb begin
        cnt_nxt  = cnt_dec;
        miss_set = 1'b0;
        if (hit) begin
            if (cnt_dec == '0 || RETRIG != 0) begin
                cnt_nxt = LEN;
            end else begin
                miss_set = 1'b1;
            end
        end
    end

    assign out_nxt = (cnt_nxt != '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            prev   <= chk;
            cnt    <= '0;
            out    <= 1'b0;
            missed <= 1'b0;
        end else begin
            prev   <= chk;
            cnt    <= cnt_nxt;
            out    <= out_nxt;
            missed <= miss_set | (missed & ~clear_missed);
        end
    end

endmodule

// File: rtl/edge_pulse_gen.sv
// Multi-channel edge-to-pulse generator; define EDGE_PULSE_SYNC_EN
// to put a 2-flop synchronizer in front of every channel.
module edge_pulse_gen
    import edge_pulse_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int PULSE_LEN = 1,
    parameter int RETRIG    = 0
) (
    input  logic              clock,
    input  logic              reset,
    edge_pulse_gen_if.slave   bus
);

    logic [CHANNELS-1:0] chk;
    logic [CHANNELS-1:0] out_nxt;
    logic [CHANNELS-1:0] out_q;
    logic [CHANNELS-1:0] miss_q;
    logic                any_q;

`ifdef EDGE_PULSE_SYNC_EN
    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.check;
            sync2 <= sync1;
        end
    end

    assign chk = sync2;
`else
    assign chk = bus.check;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        edge_pulse_chan #(
            .PULSE_LEN (PULSE_LEN),
            .RETRIG    (RETRIG)
        ) u_chan (
            .clock        (clock),
            .reset        (reset),
            .chk          (chk[g]),
            .mode         (bus.mode[2*g +: 2]),
            .enable       (bus.enable),
            .clear_missed (bus.clear_missed[g]),
            .out          (out_q[g]),
            .out_nxt      (out_nxt[g]),
            .missed       (miss_q[g])
        );
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |out_nxt;
        end
    end

    assign bus.out     = out_q;
    assign bus.missed  = miss_q;
    assign bus.any_out = any_q;

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Scoreboard bench: five pulse-length/retrigger configurations share one random stimulus stream.
module tb_edge_pulse_gen;

    localparam int NCFG = 5;
    localparam int PLS[NCFG] = '{1, 2, 3, 4, 4};
    localparam int RTS[NCFG] = '{0, 0, 0, 0, 1};

    typedef struct {
        logic [NCFG-1:0][3:0] out;
        logic [NCFG-1:0]      any;
        logic [NCFG-1:0][3:0] miss;
    } exp_t;

    logic       clock;
    logic       reset;
    logic [3:0] check;
    logic [7:0] mode;
    logic       enable;
    logic [3:0] clear_missed;

    logic [NCFG-1:0][3:0] out_v;
    logic [NCFG-1:0]      any_v;
    logic [NCFG-1:0][3:0] miss_v;

    exp_t q[$];
    exp_t got;
    int   checks;
    int   fails;
    int   mk;
    bit   done;

    int         end_t[NCFG][4];
    bit         prv[NCFG][4];
    bit         mss[NCFG][4];
    int         k;
    logic [3:0] ms1;
    logic [3:0] ms2;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        edge_pulse_gen_if #(.CHANNELS(4)) bus ();

        assign bus.check        = check;
        assign bus.mode         = mode;
        assign bus.enable       = enable;
        assign bus.clear_missed = clear_missed;
        assign out_v[g]         = bus.out;
        assign any_v[g]         = bus.any_out;
        assign miss_v[g]        = bus.missed;

        edge_pulse_gen #(
            .CHANNELS  (4),
            .PULSE_LEN (PLS[g]),
            .RETRIG    (RTS[g])
        ) dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus.slave)
        );
    end

    // Reference: each pulse is an interval [start, end) in edge-index time.
    task automatic step(input logic [3:0] c, input logic [7:0] m,
                        input logic en, input logic [3:0] clr,
                        input logic rst);
        exp_t       e;
        logic [3:0] eff;
        bit         r, f, hit, set;
        check        = c;
        mode         = m;
        enable       = en;
        clear_missed = clr;
        reset        = rst;
`ifdef EDGE_PULSE_SYNC_EN
        eff = ms2;
        ms2 = rst ? ms1 : 4'h0;
        ms1 = rst ? c : 4'h0;
`else
        eff = c;
`endif
        for (int cf = 0; cf < NCFG; cf++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (!rst) begin
                    prv[cf][ch]   = eff[ch];
                    end_t[cf][ch] = 0;
                    mss[cf][ch]   = 0;
                end else begin
                    r   = eff[ch] && !prv[cf][ch];
                    f   = !eff[ch] && prv[cf][ch];
                    hit = en && ((m[2*ch] && r) || (m[2*ch+1] && f));
                    set = 0;
                    if (hit) begin
                        if (end_t[cf][ch] > k && RTS[cf] == 0) set = 1;
                        else end_t[cf][ch] = k + PLS[cf];
                    end
                    mss[cf][ch] = set || (mss[cf][ch] && !clr[ch]);
                    prv[cf][ch] = eff[ch];
                end
                e.out[cf][ch]  = (k < end_t[cf][ch]);
                e.miss[cf][ch] = mss[cf][ch];
            end
            e.any[cf] = |e.out[cf];
        end
        q.push_back(e);
        k++;
        @(negedge clock);
    endtask

    always @(posedge clock) begin
        #1;
        if (!done) begin
            checks++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL underflow cycle %0d: no expectation queued", mk);
            end else begin
                got = q.pop_front();
                for (int cf = 0; cf < NCFG; cf++) begin
                    checks += 3;
                    if (out_v[cf] !== got.out[cf]) begin
                        fails++;
                        $display("FAIL out cfg%0d cycle %0d: got %b want %b",
                                 cf, mk, out_v[cf], got.out[cf]);
                    end
                    if (any_v[cf] !== got.any[cf]) begin
                        fails++;
                        $display("FAIL any_out cfg%0d cycle %0d: got %b want %b",
                                 cf, mk, any_v[cf], got.any[cf]);
                    end
                    if (miss_v[cf] !== got.miss[cf]) begin
                        fails++;
                        $display("FAIL missed cfg%0d cycle %0d: got %b want %b",
                                 cf, mk, miss_v[cf], got.miss[cf]);
                    end
                end
            end
            mk++;
        end
    end

    initial begin
        logic [3:0] c;
        logic [7:0] m;
        logic       en;
        logic [3:0] clr;
        logic       rst;
        checks = 0;
        fails  = 0;
        mk     = 0;
        k      = 0;
        done   = 0;
        ms1    = 4'h0;
        ms2    = 4'h0;
        m      = 8'b01_01_01_01;
        // Reset held with all inputs high, then released: no pulses.
        repeat (3) step(4'hF, m, 1'b1, 4'h0, 1'b0);
        repeat (3) step(4'hF, m, 1'b1, 4'h0, 1'b1);
        repeat (2) step(4'h0, m, 1'b1, 4'h0, 1'b1);
        // Single rise held high on channel 0.
        repeat (5) step(4'h1, m, 1'b1, 4'h0, 1'b1);
        // Channel 1 in fall mode.
        m = 8'b01_01_10_01;
        repeat (5) step(4'h3, m, 1'b1, 4'h0, 1'b1);
        repeat (6) step(4'h1, m, 1'b1, 4'h0, 1'b1);
        // Channel 2 in both mode, toggling every 4 cycles.
        m = 8'b01_11_10_01;
        for (int t = 0; t < 4; t++)
            repeat (4) step((t % 2 == 0) ? 4'h5 : 4'h1, m, 1'b1, 4'h0, 1'b1);
        // Second rise on channel 0 two cycles after the first.
        m = 8'b01_01_01_01;
        repeat (2) step(4'h0, m, 1'b1, 4'h0, 1'b1);
        step(4'h1, m, 1'b1, 4'h0, 1'b1);
        step(4'h0, m, 1'b1, 4'h0, 1'b1);
        repeat (6) step(4'h1, m, 1'b1, 4'h0, 1'b1);
        step(4'h1, m, 1'b1, 4'h1, 1'b1);
        repeat (2) step(4'h1, m, 1'b1, 4'h0, 1'b1);
        // Missed edge coinciding with clear_missed.
        step(4'h0, m, 1'b1, 4'h0, 1'b1);
        step(4'h1, m, 1'b1, 4'h0, 1'b1);
        step(4'h0, m, 1'b1, 4'h0, 1'b1);
        step(4'h1, m, 1'b1, 4'h1, 1'b1);
        repeat (5) step(4'h1, m, 1'b1, 4'h0, 1'b1);
        // Reset mid-pulse.
        step(4'h0, m, 1'b1, 4'h0, 1'b1);
        step(4'h1, m, 1'b1, 4'h0, 1'b1);
        step(4'h1, m, 1'b1, 4'h0, 1'b0);
        repeat (3) step(4'h1, m, 1'b1, 4'h0, 1'b1);
        // Rise while disabled, then re-enable while held.
        step(4'h0, m, 1'b1, 4'h0, 1'b1);
        step(4'h2, m, 1'b0, 4'h0, 1'b1);
        repeat (4) step(4'h2, m, 1'b1, 4'h0, 1'b1);
        // Both mode: rise then fall on consecutive cycles.
        m = 8'b11_11_11_11;
        step(4'h0, m, 1'b1, 4'h0, 1'b1);
        step(4'hF, m, 1'b1, 4'h0, 1'b1);
        repeat (6) step(4'h0, m, 1'b1, 4'h0, 1'b1);
        // Mode off.
        m = 8'h00;
        for (int t = 0; t < 6; t++)
            step((t % 2 == 0) ? 4'hF : 4'h0, m, 1'b1, 4'h0, 1'b1);
        // Randomised traffic.
        c = 4'h0;
        m = 8'b11_10_01_11;
        for (int t = 0; t < 600; t++) begin
            c ^= 4'($urandom & $urandom);
            if ($urandom_range(0, 15) == 0) m = 8'($urandom);
            en  = ($urandom_range(0, 9) != 0);
            clr = 4'($urandom & $urandom & $urandom);
            rst = ($urandom_range(0, 59) != 0);
            step(c, m, en, clr, rst);
        end
        done = 1;
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/edge_pulse_gen.md
Name: edge_pulse_gen

Overview:
- Parametrised, multi-channel successor to the single-channel level-to-pulse block.
- Each channel detects rising, falling or both edges on its input level and emits a registered output pulse of programmable length.
- Optional retrigger, plus a sticky per-channel "missed edge" flag.
- Sits between slow level sources (buttons, status lines) and control FSMs that need one-shot strobes.

Parameters:
- CHANNELS, 4, number of independent channels (>=1).
- PULSE_LEN, 1, output pulse length in clock cycles (>=1).
- RETRIG, 0, 1 = an edge during an active pulse reloads the pulse counter; 0 = the edge is ignored and flagged as missed.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 resets the block).
- check  input  CHANNELS  level inputs, one bit per channel.
- mode  input  2*CHANNELS  per-channel detect mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
- enable  input  1  global detect enable.
- clear_missed  input  CHANNELS  per-channel synchronous clear of the missed flag.
- out  output  CHANNELS  per-channel pulse.
- any_out  output  1  OR of out, registered alongside it.
- missed  output  CHANNELS  sticky per-channel flag: an edge was dropped.

Behaviour:
- Per-channel state:
  - prev: 1 bit, the last sampled check.
  - cnt: width $clog2(PULSE_LEN+1), remaining pulse cycles.
  - miss: 1 bit.
- Reset (reset==0 at a clock edge):
  - prev[i] <= check[i], so a high level at reset release creates no edge.
  - cnt <= 0, out <= 0, any_out <= 0, missed <= 0.
- Edge detect (combinational, sampled at each clock edge): rise = check & ~prev, fall = ~check & prev.
  - hit = enable & ((mode[0] & rise) | (mode[1] & fall)).
  - prev <= check every non-reset cycle, regardless of enable or mode.
- Pulse:
  - Idle (cnt==0) and hit: cnt <= PULSE_LEN.
  - Active (cnt>0): cnt decrements each cycle.
  - out[i] is registered and equals (next cnt != 0).
  - Latency: an input change setting up before clock edge k asserts out from edge k for exactly PULSE_LEN cycles.
- Retrigger (cnt>0 and hit):
  - RETRIG=1: cnt <= PULSE_LEN, so out stays high continuously.
  - RETRIG=0: cnt keeps decrementing and miss <= 1.
- missed:
  - Cleared by clear_missed[i]=1.
  - Set wins over clear when both occur in the same cycle.
  - With RETRIG=1 it never sets.
- Mode or enable changes mid-pulse do not truncate the pulse. They only affect new detections.
- Mode 00 never produces out.
- PULSE_LEN=1 gives a single-cycle pulse. Back-to-back edges on consecutive cycles cannot both be caught except in mode 11: rise at k and fall at k+1 gives out high k..k+1; with RETRIG=0 and PULSE_LEN=1 the first pulse has just expired, so no miss is flagged.
- Reset mid-pulse: out drops on the reset edge and the counter clears.
- Channels are fully independent. any_out is high in any cycle some out bit is high.

Optional Feature:
- Macro EDGE_PULSE_SYNC_EN.
- Defined: check passes through a 2-flop synchronizer per channel before edge detect.
  - Adds 2 cycles of latency.
  - Synchronizer flops reset to 0, and prev is loaded from the synchronizer output.
  - A high input at reset release therefore produces one rise edge 2 cycles later. This is documented, intended behaviour.
- Undefined: check feeds edge detect directly, with the latency above.

Decomposition:
- Shared package edge_pulse_pkg holds:
  - mode localparams MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11.
  - a helper function for counter width.
- One sub-module, edge_pulse_chan: a single channel (prev, cnt, miss), instantiated CHANNELS times by a generate loop.
- The top level holds the optional synchronizer and any_out.

Test Plan:
- CHANNELS=4, PULSE_LEN=1, all mode 01; check[0] 0->1 and held -> out[0] high exactly 1 cycle; no further pulse while held; other bits 0.
- PULSE_LEN=3, mode[1]=10, check[1] 1->0 -> out[1] high 3 cycles; check[1] 0->1 -> no pulse.
- Mode 11, PULSE_LEN=2, check[2] toggles every 4 cycles -> a 2-cycle pulse on each toggle; any_out mirrors.
- RETRIG=0, PULSE_LEN=4, second rise 2 cycles after the first (toggle down/up) -> out high 4 cycles only; missed[0]=1 until clear_missed[0]; simultaneous clear and new miss -> stays 1.
- RETRIG=1, same stimulus -> out high 6 continuous cycles; missed stays 0.
- Hold reset low with check=4'hF, release -> no pulses; assert reset mid-pulse -> out=0 on that edge; enable=0 during rise -> no pulse, prev still updates.
